// File: rtl/wb_burst_traffic_gen.sv
// Wishbone burst traffic generator: writes an N-beat LFSR pattern, reads it back
// and compares, reporting pass/fail, error count, first failing address and timeout.
module wb_burst_traffic_gen #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          sdr_init_done,
  input  logic          start,
  input  logic [AW-1:0] cfg_base_addr,
  input  logic [7:0]    cfg_len,
  input  logic [DW-1:0] cfg_seed,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [2:0]    wb_cti_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [DW-1:0] LFSR_TAPS = DW'(32'h8020_0003);
  localparam int            WDW       = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WR,
    S_GAP,
    S_RD,
    S_DONE
  } state_t;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
    return {1'b0, s[DW-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  state_t         r_state;
  logic [AW-1:0]  r_base;
  logic [7:0]     r_len_m1;
  logic [DW-1:0]  r_seed;
  logic [DW-1:0]  r_lfsr;
  logic [7:0]     r_beat;
  logic [WDW-1:0] r_wdog;
  logic           r_cyc;
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_dat;
  logic           r_busy;
  logic           r_done;
  logic           r_timeout;
  logic [15:0]    r_err_cnt;
  logic [AW-1:0]  r_first_err_addr;

  logic           w_ack;
  logic           w_last;
  logic           w_wd_expired;
  logic           w_mismatch;
  logic [7:0]     w_beat_nxt;
  logic [AW-1:0]  w_addr_nxt;
  logic [DW-1:0]  w_lfsr_nxt;
  logic [DW-1:0]  w_seed;

  // Beats are counted 0..len-1; storing len-1 in 8 bits makes len=0 mean 256 for free.
  assign w_ack        = wb_ack_i & r_cyc;
  assign w_last       = (r_beat == r_len_m1);
  assign w_wd_expired = (r_wdog == WD_LAST);
  assign w_mismatch   = (wb_dat_i != r_lfsr);
  assign w_beat_nxt   = r_beat + 8'd1;
  assign w_addr_nxt   = r_base + AW'(w_beat_nxt);
  assign w_lfsr_nxt   = lfsr_step(r_lfsr);
  assign w_seed       = (cfg_seed == '0) ? DW'(1) : cfg_seed;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the pre-edge values of all registers regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_len_m1         <= '0;
      r_seed           <= DW'(1);
      r_lfsr           <= DW'(1);
      r_beat           <= '0;
      r_wdog           <= '0;
      r_cyc            <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= '0;
      r_dat            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_base           <= cfg_base_addr;
            r_len_m1         <= cfg_len - 8'd1;
            r_seed           <= w_seed;
            r_lfsr           <= w_seed;
            r_beat           <= '0;
            r_wdog           <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_timeout        <= 1'b0;
            r_done           <= 1'b0;
            r_busy           <= 1'b1;
            if (sdr_init_done) begin
              r_state <= S_WR;
              r_cyc   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= cfg_base_addr;
              r_dat   <= w_seed;
            end else begin
              r_state <= S_WAIT_INIT;
            end
          end
        end

        S_WAIT_INIT: begin
          if (sdr_init_done) begin
            r_state <= S_WR;
            r_cyc   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= r_base;
            r_dat   <= r_lfsr;
            r_wdog  <= '0;
          end
        end

        S_WR, S_RD: begin
          if (w_ack) begin
            r_wdog <= '0;
            if (r_state == S_RD && w_mismatch) begin
              if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
              if (r_err_cnt == 16'd0)    r_first_err_addr <= r_addr;
            end
            if (w_last) begin
              // Address/data stay on the bus as last driven; only the cycle drops.
              r_cyc <= 1'b0;
              r_we  <= 1'b0;
              if (r_state == S_WR) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_beat <= w_beat_nxt;
              r_addr <= w_addr_nxt;
              r_lfsr <= w_lfsr_nxt;
              if (r_state == S_WR) r_dat <= w_lfsr_nxt;
            end
          end else if (w_wd_expired) begin
            r_state   <= S_DONE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end

        S_GAP: begin
          r_state <= S_RD;
          r_lfsr  <= r_seed;
          r_beat  <= '0;
          r_wdog  <= '0;
          r_cyc   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= r_base;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // cyc and stb share one flop so the async reset drops both at once.
  assign wb_cyc_o       = r_cyc;
  assign wb_stb_o       = r_cyc;
  assign wb_we_o        = r_we;
  assign wb_sel_o       = {4{r_cyc}};
  assign wb_cti_o       = 3'b000;
  assign wb_addr_o      = r_addr;
  assign wb_dat_o       = r_dat;
  assign busy           = r_busy;
  assign done           = r_done;
  assign timeout        = r_timeout;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;
  assign pass           = r_done & (r_err_cnt == 16'd0) & ~r_timeout;

endmodule

// File: tb/tb_wb_burst_traffic_gen.sv
// Self-checking bench for wb_burst_traffic_gen: a Wishbone slave memory with random
// wait states, and a per-run expected-transaction list built from the LFSR rule.
module tb_wb_burst_traffic_gen;
  localparam int AW      = 26;
  localparam int TIMEOUT = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [7:0]    cfg_len = '0;
  logic [31:0]   cfg_seed = '0;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [AW-1:0] addr;
  logic [31:0]   dat_o;
  logic          ack = 1'b0;
  logic [31:0]   dat_i = '0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  always #5 clk = ~clk;

  wb_burst_traffic_gen #(.AW(AW), .DW(32), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init_done),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_len       (cfg_len),
    .cfg_seed      (cfg_seed),
    .wb_cyc_o      (cyc),
    .wb_stb_o      (stb),
    .wb_we_o       (we),
    .wb_sel_o      (sel),
    .wb_cti_o      (cti),
    .wb_addr_o     (addr),
    .wb_dat_o      (dat_o),
    .wb_ack_i      (ack),
    .wb_dat_i      (dat_i),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] log_wr_addr[$];
  logic [31:0]   log_wr_dat[$];
  logic [AW-1:0] log_rd_addr[$];

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete run: drives start, plays the slave, and compares every bus cycle
  // against the precomputed list of (address, data) beats.
  task automatic run(input logic [AW-1:0] base, input logic [7:0] len, input logic [31:0] seed,
                     input int max_wait, input bit never_ack, input bit corrupt,
                     input logic [AW-1:0] corrupt_addr, input int init_delay,
                     input bit pulse_mid, input int reset_beat);
    logic [AW-1:0] ea[256];
    logic [31:0]   ed[256];
    logic [31:0]   s;
    logic [AW-1:0] exp_first;
    int n, i, phase, w, cnt, it, exp_err, budget;
    bit finished;

    n = (len == 8'd0) ? 256 : int'(len);
    s = (seed == 32'd0) ? 32'd1 : seed;
    exp_err = 0;
    exp_first = '0;
    for (int k = 0; k < n; k++) begin
      ea[k] = base + AW'(k);
      ed[k] = s;
      s = lfsr_step(s);
      if (corrupt && ea[k] == corrupt_addr) begin
        if (exp_err == 0) exp_first = ea[k];
        exp_err++;
      end
    end
    budget = never_ack ? TIMEOUT + 100 : 2 * n * (max_wait + 1) + 100;
    log_wr_addr.delete();
    log_wr_dat.delete();
    log_rd_addr.delete();

    @(negedge clk);
    init_done     = (init_delay == 0);
    cfg_base_addr = base;
    cfg_len       = len;
    cfg_seed      = seed;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    cfg_base_addr = AW'($urandom);
    cfg_len       = 8'($urandom);
    cfg_seed      = $urandom;
    check("busy_after_start", busy, 1);
    check("done_cleared_on_start", done, 0);
    for (int k = 0; k < init_delay; k++) begin
      check("no_cyc_before_init", cyc, 0);
      if (k == init_delay - 1) init_done = 1'b1;
      @(negedge clk);
    end

    phase = 0; i = 0; cnt = 0; it = 0; finished = 0;
    w = $urandom_range(max_wait, 0);
    while (!finished) begin
      start = pulse_mid && (it == 2);
      if (start) begin
        cfg_base_addr = AW'($urandom);
        cfg_len       = 8'd1;
        cfg_seed      = $urandom;
      end
      ack   = 1'b0;
      dat_i = $urandom;
      if (it > budget) begin
        check("run_cycle_budget", it, budget);
        finished = 1;
      end else begin
        case (phase)
          0, 2: begin
            if (never_ack) begin
              if (cyc) begin
                cnt++;
                check("to_addr_held", addr, ea[0]);
              end else begin
                check("timeout_cyc_cycles", cnt, TIMEOUT);
                check("timeout_flag", timeout, 1);
                check("timeout_done", done, 1);
                check("timeout_pass", pass, 0);
                check("timeout_busy", busy, 0);
                check("timeout_stb", stb, 0);
                finished = 1;
              end
            end else begin
              check("beat_cyc", cyc, 1);
              check("beat_stb", stb, 1);
              check("beat_we", we, (phase == 0));
              check("beat_addr", addr, ea[i]);
              if (phase == 0) check("beat_wdat", dat_o, ed[i]);
              check("beat_sel", sel, 4'hF);
              check("beat_cti", cti, 3'b000);
              check("beat_busy", busy, 1);
              if (phase == 0 && i == reset_beat) begin
                rst = 1'b1;
                #1;
                check("rst_async_cyc", cyc, 0);
                check("rst_async_stb", stb, 0);
                check("rst_async_busy", busy, 0);
                check("rst_async_done", done, 0);
                @(negedge clk);
                rst = 1'b0;
                finished = 1;
              end else if (w == 0) begin
                ack = 1'b1;
                if (phase == 0) begin
                  mem[addr] = dat_o;
                  log_wr_addr.push_back(addr);
                  log_wr_dat.push_back(dat_o);
                end else begin
                  dat_i = mem.exists(addr) ? mem[addr] : 32'h0;
                  if (corrupt && addr == corrupt_addr) dat_i[0] = ~dat_i[0];
                  log_rd_addr.push_back(addr);
                end
                i++;
                w = $urandom_range(max_wait, 0);
                if (i == n) begin
                  phase++;
                  i = 0;
                end
              end else begin
                w--;
              end
            end
          end
          1: begin
            check("gap_cyc", cyc, 0);
            check("gap_stb", stb, 0);
            check("gap_we", we, 0);
            ack = 1'b1;  // stray ack while no cycle is open must be ignored
            phase = 2;
          end
          default: begin
            check("end_done", done, 1);
            check("end_busy", busy, 0);
            check("end_cyc", cyc, 0);
            check("end_we", we, 0);
            check("end_err_cnt", err_cnt, exp_err);
            check("end_first_err", first_err_addr, exp_first);
            check("end_pass", pass, (exp_err == 0));
            check("end_timeout", timeout, 0);
            finished = 1;
          end
        endcase
      end
      if (!finished) begin
        @(negedge clk);
        it++;
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] b;
    repeat (3) @(negedge clk);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_sel", sel, 0);
    check("rst_addr", addr, 0);
    check("rst_dat", dat_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err", first_err_addr, 0);
    rst = 1'b0;

    // Nominal run; write data pinned to hand-stepped values of the LFSR rule.
    run(26'h10000, 8'd4, 32'd1, 0, 0, 0, '0, 0, 0, -1);
    check("nom_wr_count", log_wr_dat.size(), 4);
    check("nom_rd_count", log_rd_addr.size(), 4);
    if (log_wr_dat.size() == 4) begin
      check("nom_wdat0", log_wr_dat[0], 32'h0000_0001);
      check("nom_wdat1", log_wr_dat[1], 32'h8020_0003);
      check("nom_wdat2", log_wr_dat[2], 32'hC030_0002);
      check("nom_wdat3", log_wr_dat[3], 32'h6018_0001);
      check("nom_waddr3", log_wr_addr[3], 26'h10003);
    end
    check("nom_pass_lit", pass, 1);

    run(26'h10000, 8'd4, 32'd1, 0, 0, 1, 26'h10002, 0, 0, -1);
    check("mm_err_cnt_lit", err_cnt, 16'd1);
    check("mm_first_lit", first_err_addr, 26'h10002);
    check("mm_pass_lit", pass, 0);

    run(26'h3FFFFFE, 8'd4, $urandom, 1, 0, 0, '0, 0, 0, -1);
    if (log_wr_addr.size() == 4) begin
      check("wrap_a0", log_wr_addr[0], 26'h3FFFFFE);
      check("wrap_a1", log_wr_addr[1], 26'h3FFFFFF);
      check("wrap_a2", log_wr_addr[2], 26'h0000000);
      check("wrap_a3", log_wr_addr[3], 26'h0000001);
    end else begin
      check("wrap_count", log_wr_addr.size(), 4);
    end

    run(AW'($urandom), 8'd0, $urandom, 0, 0, 0, '0, 0, 0, -1);
    check("len0_writes", log_wr_addr.size(), 256);
    check("len0_reads", log_rd_addr.size(), 256);

    run(AW'($urandom), 8'd6, $urandom, 3, 0, 0, '0, 50, 0, -1);
    run(AW'($urandom), 8'd12, $urandom, 3, 0, 0, '0, 0, 1, -1);

    for (int r = 0; r < 8; r++) begin
      b = AW'($urandom);
      run(b, 8'($urandom_range(40, 1)), (r == 0) ? 32'd0 : $urandom, 3,
          0, (r % 3 == 1), b + AW'(r), 0, 0, -1);
    end

    run(AW'($urandom), 8'd8, $urandom, 0, 1, 0, '0, 0, 0, -1);

    run(26'h20000, 8'd8, $urandom, 0, 0, 0, '0, 0, 0, 1);
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_err_cnt", err_cnt, 0);
    run(26'h20000, 8'd8, $urandom, 2, 0, 0, '0, 0, 0, -1);
    check("post_rst_pass", pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
